// File: rtl/targeting_system.sv
// targeting_system: serial-pattern recognizer for the torpedo targeting path.
// Watches a 3-bit sensor code for calibration (two syncs), a left/right gate
// pair and then a bounded core-search window. When enough core signatures
// arrive inside the window, a one-cycle registered proton_fire pulse is issued.
// Abort codes, malformed sequences and window expiry fall back to IDLE silently.
// There is no handshake: one sensor code is consumed on every rising edge,
// unconditionally.
module targeting_system #(
    parameter logic [2:0] SYNC_CODE      = 3'd7,
    parameter logic [2:0] LEFT_CODE      = 3'd1,
    parameter logic [2:0] RIGHT_CODE     = 3'd2,
    parameter logic [2:0] CORE_CODE      = 3'd4,
    parameter logic [2:0] ABORT_CODE     = 3'd5,
    parameter int         WINDOW_LEN     = 4,
    parameter int         CORES_REQUIRED = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sensor_in,
    output logic       proton_fire
);

    localparam int WIN_W  = $clog2(WINDOW_LEN + 1);
    localparam int CORE_W = $clog2(CORES_REQUIRED + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_LEN);
    localparam logic [CORE_W-1:0] CORE_LAST = CORE_W'(CORES_REQUIRED);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC1  = 3'd1,
        SYNC2  = 3'd2,
        NOISE  = 3'd3,
        GATE_L = 3'd4,
        WINDOW = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIN_W-1:0]   win_cnt;
    logic [WIN_W-1:0]   win_nxt;
    logic [CORE_W-1:0]  core_cnt;
    logic [CORE_W-1:0]  core_nxt;
    logic               fire_nxt;

    // State, counters and the fire pulse register; reset drops them all at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win_cnt     <= '0;
            core_cnt    <= '0;
            proton_fire <= 1'b0;
        end else begin
            state       <= state_nxt;
            win_cnt     <= win_nxt;
            core_cnt    <= core_nxt;
            proton_fire <= fire_nxt;
        end
    end

    // Next-state, counter updates and fire decision from the sampled code.
    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        core_nxt  = core_cnt;
        fire_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (sensor_in == SYNC_CODE) state_nxt = SYNC1;
            end

            SYNC1: begin
                state_nxt = (sensor_in == SYNC_CODE) ? SYNC2 : IDLE;
            end

            SYNC2: begin
                if (sensor_in == LEFT_CODE)      state_nxt = GATE_L;
                else if (sensor_in == SYNC_CODE) state_nxt = NOISE;
                else                             state_nxt = IDLE;
            end

            // A run of three or more syncs is treated as noise; the first
            // non-sync sample is swallowed rather than interpreted.
            NOISE: begin
                if (sensor_in != SYNC_CODE) state_nxt = IDLE;
            end

            GATE_L: begin
                if (sensor_in == RIGHT_CODE) begin
                    state_nxt = WINDOW;
                    win_nxt   = '0;
                    core_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end

            // Abort beats everything; a completing core beats window expiry.
            WINDOW: begin
                win_nxt = win_cnt + 1'b1;
                if (sensor_in == ABORT_CODE) begin
                    state_nxt = IDLE;
                    win_nxt   = '0;
                    core_nxt  = '0;
                end else if ((sensor_in == CORE_CODE) &&
                             (core_cnt + 1'b1 == CORE_LAST)) begin
                    state_nxt = IDLE;
                    core_nxt  = core_cnt + 1'b1;
                    fire_nxt  = 1'b1;
                end else begin
                    if (sensor_in == CORE_CODE) core_nxt = core_cnt + 1'b1;
                    if (win_nxt == WIN_LAST)    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_targeting_system.sv
// Bench for targeting_system: directed sensor sequences, a sequence-level
// reference model feeding an expected-fire queue, one per-cycle compare
// process, and hand-written expectations that pin the model.
module tb_targeting_system;

    logic       clk;
    logic       rst_n;
    logic [2:0] sensor_in;
    logic       proton_fire;

    int checks = 0;
    int fails  = 0;

    logic [0:0] exp_q[$];

    targeting_system dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_in  (sensor_in),
        .proton_fire(proton_fire)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks progress as "how many consecutive syncs", "left gate seen",
    // "in noise" and the list of samples taken inside the core window.
    int         m_sync_run;
    bit         m_noise;
    bit         m_left_seen;
    bit         m_in_window;
    logic [2:0] m_win_q[$];

    task automatic model_reset();
        m_sync_run  = 0;
        m_noise     = 1'b0;
        m_left_seen = 1'b0;
        m_in_window = 1'b0;
        m_win_q.delete();
    endtask

    task automatic model_step(input logic [2:0] s, output bit fire);
        int cores;
        fire = 1'b0;
        if (m_in_window) begin
            m_win_q.push_back(s);
            cores = 0;
            foreach (m_win_q[i]) if (m_win_q[i] == 3'd4) cores++;
            if (s == 3'd5)              m_in_window = 1'b0;
            else if (cores == 2) begin  fire = 1'b1; m_in_window = 1'b0; end
            else if (m_win_q.size() == 4) m_in_window = 1'b0;
        end else if (m_noise) begin
            if (s != 3'd7) m_noise = 1'b0;
        end else if (m_left_seen) begin
            m_left_seen = 1'b0;
            if (s == 3'd2) begin
                m_in_window = 1'b1;
                m_win_q.delete();
            end
        end else if (m_sync_run == 2) begin
            m_sync_run = 0;
            if (s == 3'd1)      m_left_seen = 1'b1;
            else if (s == 3'd7) m_noise     = 1'b1;
        end else begin
            m_sync_run = (s == 3'd7) ? m_sync_run + 1 : 0;
        end
    endtask

    // ---------------- check helper ----------------
    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    // Each queued entry is the expected proton_fire after one sampling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            checks++;
            if (proton_fire !== e[0]) begin
                fails++;
                $display("FAIL fire_cycle: got %b expected %b at %0t", proton_fire, e[0], $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] s, input logic hand_exp, input string tag);
        bit f;
        sensor_in = s;
        @(posedge clk);
        #1;
        model_step(s, f);
        check_bit({tag, "_model"}, f, hand_exp);
        exp_q.push_back(f);
    endtask

    // codes/exp are written left-to-right, first sample in the most significant slot.
    task automatic run_seq(input int n, input logic [35:0] codes,
                           input logic [11:0] exp_mask, input string tag);
        for (int i = 0; i < n; i++)
            send(codes[3*(n-1-i) +: 3], exp_mask[n-1-i], tag);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    // Assert reset between edges, check the output drops at once, then release.
    task automatic mid_reset(input string tag);
        drain();
        rst_n = 1'b0;
        #1;
        check_bit({tag, "_async"}, proton_fire, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sensor_in = 3'd0;
        rst_n     = 1'b1;
        model_reset();
        #3 rst_n = 1'b0;
        #1 check_bit("reset_fire", proton_fire, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // nominal fire at T=4 (core on the last window cycle), then clear
        run_seq(9, {3'd0,3'd7,3'd7,3'd1,3'd2,3'd0,3'd4,3'd0,3'd4}, 9'b000000001, "nominal");
        send(3'd0, 1'b0, "nominal_clear");

        // abort inside the window, trailing core ignored
        run_seq(7, {3'd7,3'd7,3'd1,3'd2,3'd4,3'd5,3'd4}, 7'b0000000, "abort");

        // third sync enters noise; gates and cores ignored
        run_seq(7, {3'd7,3'd7,3'd7,3'd1,3'd2,3'd4,3'd4}, 7'b0000000, "noise");

        // window expiry with a single core
        run_seq(9, {3'd7,3'd7,3'd1,3'd2,3'd4,3'd0,3'd0,3'd0,3'd4}, 9'b000000000, "expiry");

        // early fire at T=2, back to back
        run_seq(6, {3'd7,3'd7,3'd1,3'd2,3'd4,3'd4}, 6'b000001, "early1");
        run_seq(6, {3'd7,3'd7,3'd1,3'd2,3'd4,3'd4}, 6'b000001, "early2");

        // abort on the last window cycle after one core
        run_seq(8, {3'd7,3'd7,3'd1,3'd2,3'd4,3'd0,3'd0,3'd5}, 8'b00000000, "abort_t4");

        // gate ordering errors
        run_seq(7, {3'd7,3'd7,3'd2,3'd1,3'd2,3'd4,3'd4}, 7'b0000000, "gate_swap");
        run_seq(7, {3'd7,3'd7,3'd1,3'd1,3'd2,3'd4,3'd4}, 7'b0000000, "gate_rep");

        // long sync run, consumed non-sync, fresh calibration fires
        run_seq(11, {3'd7,3'd7,3'd7,3'd7,3'd0,3'd7,3'd7,3'd1,3'd2,3'd4,3'd4},
                11'b00000000001, "noise_exit");
        // the sample that exits noise is swallowed even if it is a gate
        run_seq(10, {3'd7,3'd7,3'd7,3'd1,3'd7,3'd7,3'd1,3'd2,3'd4,3'd4},
                10'b0000000001, "noise_gate");

        // async reset mid-window, then 4,4 alone must not fire
        run_seq(5, {3'd7,3'd7,3'd1,3'd2,3'd4}, 5'b00000, "rst_win");
        mid_reset("rst_win");
        run_seq(2, {3'd4,3'd4}, 2'b00, "rst_after");

        // async reset while the fire pulse is high clears it immediately
        run_seq(6, {3'd7,3'd7,3'd1,3'd2,3'd4,3'd4}, 6'b000001, "rst_fire");
        mid_reset("rst_fire");
        run_seq(3, {3'd0,3'd4,3'd4}, 3'b000, "rst_fire_after");

        drain();
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
